// File: rtl/blake2_pkg.sv
// Constants and loader state encoding shared by the BLAKE2s datapath blocks.
// Pure declarations: no logic, no latency.
// No flow control lives here.
package blake2_pkg;

    localparam int B2S_W     = 32;
    localparam int B2S_BB    = 2 * B2S_W;
    localparam int B2S_LEN_W = 32;
    localparam int BLK       = 64;
    localparam int IDX_W     = $clog2(BLK);
    localparam int B2S_KW    = $clog2(B2S_W + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_KEY,
        S_KPAD,
        S_MSG,
        S_MPAD,
        S_WAIT
    } loader_state_t;

endpackage

// File: rtl/blake2_msg_loader.sv
// Host byte stream to blake2 block feeder: key block, zero padding, first/last flags.
// Latency: push path is combinational from s_valid_i/core_ready_i, one byte per cycle.
// Backpressure: core_ready_i low stalls both pushes and host acceptance; host bubbles keep indices contiguous.
module blake2_msg_loader
    import blake2_pkg::*;
#(
    parameter int W     = B2S_W,
    parameter int LEN_W = B2S_LEN_W,
    parameter int KW    = $clog2(W + 1)
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 start_i,
    input  logic [LEN_W-1:0]     len_i,
    input  logic [KW-1:0]        kk_i,
    input  logic [KW-1:0]        nn_i,
    input  logic                 s_valid_i,
    input  logic [7:0]           s_data_i,
    output logic                 s_ready_o,
    output logic                 busy_o,
    output logic                 done_o,
    input  logic                 core_ready_i,
    output logic                 data_v_o,
    output logic [IDX_W-1:0]     data_idx_o,
    output logic [7:0]           data_o,
    output logic                 block_first_o,
    output logic                 block_last_o,
    output logic [2*W-1:0]       ll_o,
    output logic [KW-1:0]        kk_o,
    output logic [KW-1:0]        nn_o
);

    localparam int BB = 2 * W;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(BLK - 1);
    localparam logic [LEN_W-1:0] BLK_LEN  = LEN_W'(BLK);

    loader_state_t     state_q;
    logic [IDX_W-1:0]  idx_q;
    logic [LEN_W-1:0]  rem_q;
    logic [LEN_W-1:0]  len_q;
    logic [KW-1:0]     kk_q;
    logic [KW-1:0]     nn_q;
    logic [BB-1:0]     ll_q;
    logic              first_q;
    logic              last_q;
    logic              done_q;

    logic              host_st;
    logic              pad_st;
    logic              push;
    logic              idx_end;
    logic [LEN_W-1:0]  rem_dec;

    assign host_st = (state_q == S_KEY) || (state_q == S_MSG);
    assign pad_st  = (state_q == S_KPAD) || (state_q == S_MPAD);
    assign push    = core_ready_i & (host_st ? s_valid_i : pad_st);
    assign idx_end = (idx_q == IDX_LAST);
    assign rem_dec = rem_q - LEN_W'(1);

    assign data_v_o      = push;
    assign s_ready_o     = core_ready_i & host_st;
    assign data_o        = host_st ? s_data_i : 8'h00;
    assign data_idx_o    = idx_q;
    assign block_first_o = first_q;
    assign block_last_o  = last_q;
    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = done_q;
    assign ll_o          = ll_q;
    assign kk_o          = kk_q;
    assign nn_o          = nn_q;

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            rem_q   <= '0;
            len_q   <= '0;
            kk_q    <= '0;
            nn_q    <= '0;
            ll_q    <= '0;
            first_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (push) begin
                idx_q <= idx_q + IDX_W'(1);
                if (idx_end) begin
                    first_q <= 1'b0;
                end
            end
            case (state_q)
                S_IDLE: begin
                    // Start is only taken while the core can accept, so the first push is never stranded.
                    if (start_i && core_ready_i) begin
                        len_q   <= len_i;
                        kk_q    <= kk_i;
                        nn_q    <= nn_i;
                        rem_q   <= len_i;
                        ll_q    <= BB'(len_i) + ((kk_i != '0) ? BB'(BLK) : '0);
                        idx_q   <= '0;
                        first_q <= 1'b1;
                        if (kk_i != '0) begin
                            last_q  <= (len_i == '0);
                            state_q <= S_KEY;
                        end else begin
                            last_q  <= (len_i <= BLK_LEN);
                            state_q <= (len_i != '0) ? S_MSG : S_MPAD;
                        end
                    end
                end
                S_KEY: begin
                    if (push && (idx_q == IDX_W'(kk_q - KW'(1)))) begin
                        state_q <= S_KPAD;
                    end
                end
                S_KPAD: begin
                    if (push && idx_end) begin
                        if (len_q != '0) begin
                            last_q  <= (rem_q <= BLK_LEN);
                            state_q <= S_MSG;
                        end else begin
                            state_q <= S_WAIT;
                        end
                    end
                end
                S_MSG: begin
                    if (push) begin
                        rem_q <= rem_dec;
                        if (rem_dec == '0) begin
                            state_q <= idx_end ? S_WAIT : S_MPAD;
                        end else if (idx_end) begin
                            last_q <= (rem_dec <= BLK_LEN);
                        end
                    end
                end
                S_MPAD: begin
                    if (push && idx_end) begin
                        state_q <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Entry is already one cycle past the final push; ready here means the core is idle again.
                    if (core_ready_i) begin
                        done_q  <= 1'b1;
                        state_q <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule
